// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch unit: data widths, reset PC, FSM states,
// and the buffered-instruction payload.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } inst_entry_t;

  // Sequential fetch address; wraps naturally modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a one-cycle clear.
// Simultaneous push and pop are both honoured, also when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues in-order fetch requests under a credit
// limit, buffers responses for decode, and squashes stale responses on redirect.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  output logic            imemReqValid,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemReqReady,
  input  logic            imemRespValid,
  input  logic [XLEN-1:0] imemRespData,
  output logic            instValid,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instPC,
  input  logic            instReady
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   stale_cnt;

  logic [CW-1:0]   aq_count;
  logic [CW-1:0]   iq_count;
  logic            aq_empty;
  logic            iq_empty;
  logic [XLEN-1:0] aq_head;
  inst_entry_t     iq_head;
  inst_entry_t     iq_push_data;

  logic [SW-1:0]   credit;
  logic [SW-1:0]   inflight_after;
  logic            req_fire;
  logic            resp_stale;
  logic            resp_live;
  logic            inst_pop;
  logic            unused_target_bits;

  assign unused_target_bits = ^branchTarget[1:0];

  // Credit covers both outstanding requests and buffered instructions.
  assign credit       = SW'(aq_count) + SW'(iq_count);
  assign imemReqValid = (state == FETCH) && !stall && !branchTaken && (credit < SW'(DEPTH));
  assign imemReqAddr  = pc;
  assign req_fire     = imemReqValid && imemReqReady;

  // Stale responses exist only in FLUSH, when the address queue is empty.
  assign resp_stale = imemRespValid && (stale_cnt != '0);
  assign resp_live  = imemRespValid && (stale_cnt == '0) && !aq_empty;
  assign inst_pop   = instValid && instReady;

  assign inflight_after = SW'(aq_count) + SW'(stale_cnt) + SW'(req_fire)
                        - SW'(resp_stale || resp_live);

  assign iq_push_data.addr = aq_head;
  assign iq_push_data.data = imemRespData;

  assign instValid = !iq_empty;
  assign instData  = iq_head.data;
  assign instPC    = iq_head.addr;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (branchTaken),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_live),
    .head      (aq_head),
    .empty     (aq_empty),
    .count     (aq_count)
  );

  sync_fifo #(.WIDTH($bits(inst_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (branchTaken),
    .push      (resp_live),
    .push_data (iq_push_data),
    .pop       (inst_pop),
    .head      (iq_head),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  // PC, stale counter and fetch state; a redirect wins over everything else.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      stale_cnt <= '0;
    end else if (branchTaken) begin
      pc        <= {branchTarget[XLEN-1:2], 2'b00};
      stale_cnt <= CW'(inflight_after);
      state     <= (inflight_after != '0) ? FLUSH : FETCH;
    end else begin
      if (req_fire) pc <= next_pc(pc);
      unique case (state)
        IDLE:  state <= FETCH;
        FETCH: state <= FETCH;
        FLUSH: begin
          if (resp_stale) begin
            stale_cnt <= stale_cnt - CW'(1);
            if (stale_cnt == CW'(1)) state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector tables, hand-written redirect/stall/
// reset sequences, and randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPC;
  logic        instReady;

  logic        hi_req_valid;
  logic [31:0] hi_req_addr;
  logic        hi_resp_valid;
  logic [31:0] hi_resp_data;
  logic        hi_inst_valid;
  logic [31:0] hi_inst_data;
  logic [31:0] hi_inst_pc;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr),
    .imemReqReady(imemReqReady), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instValid(instValid), .instData(instData), .instPC(instPC), .instReady(instReady)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_hi (
    .clock(clock), .reset_n(reset_n), .stall(1'b0), .branchTaken(1'b0),
    .branchTarget(32'h0), .imemReqValid(hi_req_valid), .imemReqAddr(hi_req_addr),
    .imemReqReady(1'b1), .imemRespValid(hi_resp_valid), .imemRespData(hi_resp_data),
    .instValid(hi_inst_valid), .instData(hi_inst_data), .instPC(hi_inst_pc), .instReady(1'b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Instruction memory model: in-order pending requests with earliest reply cycle.
  typedef struct { logic [31:0] a; int rc; } pend_t;
  pend_t       mem_q[$];
  int          last_rc   = 0;
  int          resp_mode = 1;   // 0 hold, 1 fixed one-cycle latency, 2 random
  logic        hi_pend   = 1'b0;
  logic [31:0] hi_pend_addr = 32'h0;
  logic [31:0] hi_log[$];

  // Reference model: fetch PC, live in-flight addresses, buffered entries, stale count.
  logic [31:0] m_pc = 32'h0;
  logic        m_live = 1'b0;
  logic        m_zero = 1'b1;
  int          m_stale = 0;
  logic [31:0] m_inflight[$];
  logic [63:0] m_buf[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check 1 ns later, advance model and memory.
  task automatic step(input logic rn, input logic st, input logic br,
                      input logic [31:0] tgt, input logic rdy, input logic ir);
    logic exp_rv;
    logic [31:0] a;
    int rc;
    @(negedge clock);
    reset_n = rn; stall = st; branchTaken = br; branchTarget = tgt;
    imemReqReady = rdy; instReady = ir;
    imemRespValid = 1'b0; imemRespData = $urandom;
    if (rn && mem_q.size() > 0 && mem_q[0].rc <= cyc &&
        (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 9) < 7))) begin
      imemRespValid = 1'b1;
      imemRespData  = memf(mem_q[0].a);
      void'(mem_q.pop_front());
    end else if (rn && resp_mode == 2 && mem_q.size() == 0 && $urandom_range(0, 31) == 0) begin
      imemRespValid = 1'b1;
    end
    hi_resp_valid = rn && hi_pend;
    hi_resp_data  = memf(hi_pend_addr);
    #1;
    exp_rv = m_live && (m_stale == 0) && !st && !br && (m_inflight.size() + m_buf.size() < DEPTH);
    if (rn) begin
      chk("req_valid", 32'(imemReqValid), 32'(exp_rv));
      chk("req_addr", imemReqAddr, m_pc);
      chk("inst_valid", 32'(instValid), 32'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        chk("inst_pc", instPC, m_buf[0][63:32]);
        chk("inst_data", instData, m_buf[0][31:0]);
      end else if (m_zero) begin
        chk("inst_pc_zero", instPC, 32'h0);
        chk("inst_data_zero", instData, 32'h0);
      end
      if (hi_inst_valid) chk("hi_inst_data", hi_inst_data, memf(hi_inst_pc));
    end
    if (rn && imemReqValid && rdy) begin
      rc = cyc + 1 + ((resp_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      if (rc < last_rc) rc = last_rc;
      last_rc = rc;
      mem_q.push_back('{imemReqAddr, rc});
    end
    hi_pend = rn && hi_req_valid;
    hi_pend_addr = hi_req_addr;
    if (rn && hi_req_valid) hi_log.push_back(hi_req_addr);
    if (!rn) begin
      m_pc = 32'h0; m_live = 1'b0; m_zero = 1'b1; m_stale = 0;
      m_inflight.delete(); m_buf.delete(); mem_q.delete(); hi_log.delete();
      hi_pend = 1'b0; last_rc = 0;
    end else begin
      if (m_buf.size() != 0 && ir) void'(m_buf.pop_front());
      if (imemRespValid) begin
        if (m_stale > 0) m_stale--;
        else if (m_inflight.size() > 0) begin
          a = m_inflight.pop_front();
          m_buf.push_back({a, imemRespData});
          m_zero = 1'b0;
        end
      end
      if (exp_rv && rdy) begin
        m_inflight.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (br) begin
        m_stale = m_stale + m_inflight.size();
        m_inflight.delete();
        m_buf.delete();
        m_pc = {tgt[31:2], 2'b00};
      end
      m_live = 1'b1;
    end
    cyc++;
  endtask

  typedef struct {
    logic rst; logic st; logic ir;
    logic erv; logic [31:0] era; logic eiv; logic [31:0] eipc; logic ez;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkv(logic rst, logic st, logic ir, logic erv, logic [31:0] era,
                               logic eiv, logic [31:0] eipc, logic ez);
    vec_t v;
    v.rst = rst; v.st = st; v.ir = ir; v.erv = erv; v.era = era;
    v.eiv = eiv; v.eipc = eipc; v.ez = ez;
    return v;
  endfunction

  task automatic run_table();
    foreach (vt[i]) begin
      step(!vt[i].rst, vt[i].st, 1'b0, 32'h0, 1'b1, vt[i].ir);
      if (!vt[i].rst) begin
        chk("tbl_req_valid", 32'(imemReqValid), 32'(vt[i].erv));
        chk("tbl_req_addr", imemReqAddr, vt[i].era);
        chk("tbl_inst_valid", 32'(instValid), 32'(vt[i].eiv));
        if (vt[i].eiv) begin
          chk("tbl_inst_pc", instPC, vt[i].eipc);
          chk("tbl_inst_data", instData, memf(vt[i].eipc));
        end else if (vt[i].ez) begin
          chk("tbl_inst_pc_rst", instPC, 32'h0);
          chk("tbl_inst_data_rst", instData, 32'h0);
        end
      end
    end
    vt.delete();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    int delivered;
    logic [31:0] got;
    logic [31:0] hi_exp[3];
    reset_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
    imemReqReady = 1'b1; imemRespValid = 1'b0; imemRespData = 32'h0; instReady = 1'b1;
    hi_resp_valid = 1'b0; hi_resp_data = 32'h0;

    // Streaming fetch with decode always ready.
    resp_mode = 1;
    vt.push_back(mkv(1, 0, 1, 0, 32'h0, 0, 32'h0, 0));
    vt.push_back(mkv(1, 0, 1, 0, 32'h0, 0, 32'h0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 32'h0,  0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 1, 1, 32'h0,  0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 1, 1, 32'h4,  0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 1, 0, 32'h8,  1, 32'h0, 0));
    vt.push_back(mkv(0, 0, 1, 1, 32'h8,  1, 32'h4, 0));
    vt.push_back(mkv(0, 0, 1, 1, 32'hC,  0, 32'h0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 32'h10, 1, 32'h8, 0));
    run_table();

    // The high-reset-PC instance ran alongside: its first three requests wrap.
    hi_exp[0] = 32'hFFFF_FFF8; hi_exp[1] = 32'hFFFF_FFFC; hi_exp[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      got = (hi_log.size() > i) ? hi_log[i] : 32'hDEAD_BEEF;
      chk("hi_wrap_addr", got, hi_exp[i]);
    end

    // Decode back-pressure: two requests, then credit exhausted until a pop.
    vt.push_back(mkv(1, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    vt.push_back(mkv(1, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 0, 1, 32'h4, 0, 32'h0, 1));
    vt.push_back(mkv(0, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vt.push_back(mkv(0, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vt.push_back(mkv(0, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 32'h8, 1, 32'h0, 0));
    vt.push_back(mkv(0, 0, 1, 1, 32'h8, 1, 32'h4, 0));
    vt.push_back(mkv(0, 0, 1, 1, 32'hC, 0, 32'h0, 0));
    run_table();

    // Redirect with two requests outstanding: both responses squashed.
    do_reset(2);
    resp_mode = 0;
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 1, 1); chk("br_req0", imemReqAddr, 32'h0);
    step(1, 0, 0, 32'h0, 1, 1); chk("br_req1", imemReqAddr, 32'h4);
    step(1, 0, 1, 32'h0000_0103, 1, 1); chk("br_cycle_valid", 32'(imemReqValid), 32'h0);
    resp_mode = 1;
    step(1, 0, 0, 32'h0, 1, 1); chk("flush_valid0", 32'(imemReqValid), 32'h0);
    chk("flush_inst0", 32'(instValid), 32'h0);
    step(1, 0, 0, 32'h0, 1, 1); chk("flush_valid1", 32'(imemReqValid), 32'h0);
    chk("flush_inst1", 32'(instValid), 32'h0);
    step(1, 0, 0, 32'h0, 1, 1); chk("redir_valid", 32'(imemReqValid), 32'h1);
    chk("redir_addr", imemReqAddr, 32'h0000_0100);
    step(1, 0, 0, 32'h0, 1, 1); chk("redir_inst_wait", 32'(instValid), 32'h0);
    step(1, 0, 0, 32'h0, 1, 1); chk("redir_inst_valid", 32'(instValid), 32'h1);
    chk("redir_inst_pc", instPC, 32'h0000_0100);
    chk("redir_inst_data", instData, memf(32'h0000_0100));

    // Stall holds issue for five cycles while the buffer drains.
    do_reset(2);
    resp_mode = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 1, 1);
    delivered = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 32'h0, 1, 1);
      chk("stall_no_req", 32'(imemReqValid), 32'h0);
      if (instValid) delivered++;
    end
    chk("stall_delivered", 32'(delivered), 32'd2);
    step(1, 0, 0, 32'h0, 1, 1);
    chk("unstall_valid", 32'(imemReqValid), 32'h1);
    chk("unstall_addr", imemReqAddr, 32'h8);

    // One-cycle reset while flushing.
    do_reset(2);
    resp_mode = 1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 1, 0);
    resp_mode = 0;
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 1, 32'h0000_0200, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0); chk("pre_rst_flush", 32'(imemReqValid), 32'h0);
    do_reset(1);
    step(1, 0, 0, 32'h0, 1, 1);
    chk("rst_req_valid", 32'(imemReqValid), 32'h0);
    chk("rst_req_addr", imemReqAddr, 32'h0);
    chk("rst_inst_valid", 32'(instValid), 32'h0);
    chk("rst_inst_data", instData, 32'h0);
    chk("rst_inst_pc", instPC, 32'h0);
    step(1, 0, 0, 32'h0, 1, 1);
    chk("rst_restart", imemReqAddr, 32'h0);
    chk("rst_restart_valid", 32'(imemReqValid), 32'h1);

    // Randomized traffic, redirects, stalls, spurious responses and resets.
    resp_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0), tgt,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter: DEPTH, default 2, maximum number of requests in flight plus buffered instructions.
REQ-003 Port: clock  input  1  single rising-edge clock for all state.
REQ-004 Port: reset_n  input  1  reset; synchronous, active-low.
REQ-005 Port: stall  input  1  inhibits issue of new fetch requests.
REQ-006 Port: branchTaken  input  1  single-cycle redirect strobe.
REQ-007 Port: branchTarget  input  32  redirect address.
REQ-008 Port: imemReqValid  output  1  fetch request valid.
REQ-009 Port: imemReqAddr  output  32  fetch address (current PC).
REQ-010 Port: imemReqReady  input  1  instruction memory accepts request.
REQ-011 Port: imemRespValid  input  1  in-order response valid; never back-pressured.
REQ-012 Port: imemRespData  input  32  fetched instruction word.
REQ-013 Port: instValid  output  1  buffered instruction available to decode.
REQ-014 Port: instData  output  32  head instruction word.
REQ-015 Port: instPC  output  32  address of head instruction.
REQ-016 Port: instReady  input  1  decode consumes head when instValid is high.

Function
REQ-017 FSM states: IDLE, FETCH, FLUSH; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-018 Credit = in-flight requests + buffered instructions; imemReqValid = (state==FETCH) && !stall && !branchTaken && credit<DEPTH.
REQ-019 A request is accepted when imemReqValid && imemReqReady; PC then becomes PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 Each accepted request pushes its address into an in-order address queue of DEPTH entries.
REQ-021 A response pops the address queue and writes {address, data} into a DEPTH-entry instruction FIFO; instValid rises the following cycle (no bypass).
REQ-022 instData/instPC show the FIFO head; a pop occurs when instValid && instReady; push and pop in the same cycle are both honoured.
REQ-023 branchTaken: PC <= {branchTarget[31:2],2'b00}; instruction FIFO cleared that cycle; stale counter <= number of in-flight requests, including any accepted that same cycle.
REQ-024 If the stale counter after redirect is nonzero, state -> FLUSH; otherwise stay in or return to FETCH.
REQ-025 In FLUSH, no requests are issued; each response decrements the stale counter and is discarded, not buffered; on the last discard -> FETCH next cycle.
REQ-026 branchTaken in FLUSH reloads PC and keeps the remaining stale count; branchTaken overrides stall.
REQ-027 stall does not affect responses or the decode-side handshake; FIFO continues draining.
REQ-028 A response arriving with no outstanding request is a protocol error; it is ignored and internal state is not changed.

Reset
REQ-029 While reset_n is low at a clock edge: PC=RESET_PC, state=IDLE, FIFO and address queue empty, stale counter=0.
REQ-030 Reset output values: imemReqValid=0, instValid=0, imemReqAddr=RESET_PC, instData=0, instPC=0.
REQ-031 Reset mid-operation discards all in-flight and buffered state; instruction memory shares reset_n.

Structure
REQ-032 Shared package: XLEN=32, INST_BYTES=4, RESET_PC default, FSM state enumeration.
REQ-033 One sub-module, sync_fifo, parameterised for width and depth, instantiated for both the address queue and the instruction FIFO.

Verification
REQ-034 Reset release, imemReqReady=1, one-cycle memory latency, instReady=1 -> addresses 0,4,8 issued; instPC sequence 0,4,8 with matching data.
REQ-035 instReady=0 -> exactly 2 requests issued, then imemReqValid=0; instReady=1 -> issuing resumes at PC=8.
REQ-036 branchTaken with target 32'h0000_0103 while 2 requests are in flight -> FLUSH; 2 responses discarded; next request at 32'h0000_0100; instValid stays low until that data arrives.
REQ-037 stall=1 for 5 cycles -> no requests; buffered instructions still delivered; same PC issued after stall drops.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> requests at FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 reset_n low for 1 cycle during FLUSH -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
